// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet link.
// Frame: A5, tag, w[7:0]..w[31:24], chk (tag ^ payload bytes).
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 7;
  localparam int         IDX_W     = 3;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef enum logic {
    RX_HUNT,
    RX_COLLECT
  } rx_state_t;

  function automatic logic [7:0] frame_byte(
    input logic [7:0]  tag,
    input logic [31:0] word,
    input idx_t        idx
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = tag;
      3'd2:    b = word[7:0];
      3'd3:    b = word[15:8];
      3'd4:    b = word[23:16];
      3'd5:    b = word[31:24];
      3'd6:    b = tag ^ word[7:0] ^ word[15:8]
                 ^ word[23:16] ^ word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_pkt_rx.sv
// RX half: hunts for A5, collects tag/word, checks XOR, inter-byte timeout.
// Ports: CLK, RST, uart_recv_* FIFO side, rx_valid/rx_tag/rx_word/rx_err.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  uart_recv_data,
  input  logic        uart_receivable,
  output logic        uart_recv_flag,
  output logic        rx_valid,
  output logic [7:0]  rx_tag,
  output logic [31:0] rx_word,
  output logic        rx_err
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  rx_state_t        state, state_n;
  idx_t             idx;
  logic [7:0]       xsum;
  logic [7:0]       tag_sh;
  logic [31:0]      word_sh;
  logic [CNT_W-1:0] cnt;

  logic pop, last, good, bad, tmo;

  always_comb begin
    state_n = state;
    pop     = uart_receivable && !uart_recv_flag;
    last    = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      RX_HUNT: begin
        if (pop && uart_recv_data == SYNC_BYTE)
          state_n = RX_COLLECT;
      end
      RX_COLLECT: begin
        last = pop && (idx == LAST_IDX);
        good = last && (uart_recv_data == xsum);
        bad  = last && (uart_recv_data != xsum);
        tmo  = !pop && (cnt == TMO_LAST);
        if (last || tmo)
          state_n = RX_HUNT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RX_HUNT;
    else     state <= state_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      uart_recv_flag <= 1'b0;
      rx_valid       <= 1'b0;
      rx_err         <= 1'b0;
      rx_tag         <= 8'h00;
      rx_word        <= 32'h0;
      idx            <= '0;
      xsum           <= 8'h00;
      tag_sh         <= 8'h00;
      word_sh        <= 32'h0;
      cnt            <= '0;
    end else begin
      uart_recv_flag <= pop;
      rx_valid       <= good;
      rx_err         <= bad || tmo;
      if (good) begin
        rx_tag  <= tag_sh;
        rx_word <= word_sh;
      end
      // Timeout only runs between pops of a frame.
      if (pop || tmo || state == RX_HUNT)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == RX_HUNT) begin
        if (pop && uart_recv_data == SYNC_BYTE) begin
          idx  <= 3'd1;
          xsum <= 8'h00;
        end
      end else if (pop) begin
        idx  <= idx + 3'd1;
        xsum <= xsum ^ uart_recv_data;
        if (idx == 3'd1)
          tag_sh <= uart_recv_data;
        else if (idx != LAST_IDX)
          // Little-endian bytes shift in from the top.
          word_sh <= {uart_recv_data, word_sh[31:8]};
      end
    end
  end

endmodule

// File: rtl/uart_packet_link.sv
// Packet layer over the UART byte FIFOs: 7-byte tagged frames, TX and RX.
// Ports: CLK, RST, tx_* request, rx_* delivery, uart_* FIFO handshakes.
module uart_packet_link
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_tag,
  input  logic [31:0] tx_word,
  output logic        rx_valid,
  output logic [7:0]  rx_tag,
  output logic [31:0] rx_word,
  output logic        rx_err,
  output logic        uart_send_flag,
  output logic [7:0]  uart_send_data,
  input  logic        uart_sendable,
  output logic        uart_recv_flag,
  input  logic [7:0]  uart_recv_data,
  input  logic        uart_receivable
);

  tx_state_t   tx_state, tx_state_n;
  idx_t        tx_idx;
  logic [7:0]  tag_q;
  logic [31:0] word_q;
  logic        accept, push;

  assign tx_ready = (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    accept     = 1'b0;
    push       = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        accept = tx_valid;
        if (tx_valid)
          tx_state_n = TX_SEND;
      end
      TX_SEND: begin
        // Flag is registered, so FIFO status is stale for one cycle.
        push = uart_sendable && !uart_send_flag;
        if (push && tx_idx == LAST_IDX)
          tx_state_n = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_idx         <= '0;
      tag_q          <= 8'h00;
      word_q         <= 32'h0;
      uart_send_flag <= 1'b0;
      uart_send_data <= 8'h00;
    end else begin
      uart_send_flag <= push;
      if (accept) begin
        tag_q  <= tx_tag;
        word_q <= tx_word;
        tx_idx <= '0;
      end
      if (push) begin
        uart_send_data <= frame_byte(tag_q, word_q, tx_idx);
        tx_idx         <= tx_idx + 3'd1;
      end
    end
  end

  uart_pkt_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLK             (CLK),
    .RST             (RST),
    .uart_recv_data  (uart_recv_data),
    .uart_receivable (uart_receivable),
    .uart_recv_flag  (uart_recv_flag),
    .rx_valid        (rx_valid),
    .rx_tag          (rx_tag),
    .rx_word         (rx_word),
    .rx_err          (rx_err)
  );

endmodule

// File: tb/tb_uart_packet_link.sv
// Directed bench for uart_packet_link with a simple FIFO model.
// Checks TX framing/stall, RX hunt/check/timeout and mid-frame reset.
module tb_uart_packet_link;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_tag;
  logic [31:0] tx_word;
  logic        rx_valid;
  logic [7:0]  rx_tag;
  logic [31:0] rx_word;
  logic        rx_err;
  logic        uart_send_flag;
  logic [7:0]  uart_send_data;
  logic        uart_sendable;
  logic        uart_recv_flag;
  logic [7:0]  uart_recv_data;
  logic        uart_receivable;

  always #5 clk = ~clk;

  uart_packet_link #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .CLK             (clk),
    .RST             (rst),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_tag          (tx_tag),
    .tx_word         (tx_word),
    .rx_valid        (rx_valid),
    .rx_tag          (rx_tag),
    .rx_word         (rx_word),
    .rx_err          (rx_err),
    .uart_send_flag  (uart_send_flag),
    .uart_send_data  (uart_send_data),
    .uart_sendable   (uart_sendable),
    .uart_recv_flag  (uart_recv_flag),
    .uart_recv_data  (uart_recv_data),
    .uart_receivable (uart_receivable)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rxq   [$];
  logic [7:0] txlog [$];
  int         txcyc [$];
  int npop, last_pop, nvalid, valid_cyc, nerr, err_cyc;

  logic [7:0] exp_a [7] = '{8'hA5, 8'h12, 8'hEF, 8'hBE,
                            8'hAD, 8'hDE, 8'h30};
  logic [7:0] exp_b [7] = '{8'hA5, 8'h5A, 8'h44, 8'h33,
                            8'h22, 8'h11, 8'h1E};
  logic [7:0] v_good [9] = '{8'h00, 8'hFF, 8'hA5, 8'h12, 8'hEF,
                             8'hBE, 8'hAD, 8'hDE, 8'h30};
  logic [7:0] v_bad1 [7] = '{8'hA5, 8'h12, 8'hEF, 8'hBE,
                             8'hAD, 8'hDE, 8'h31};
  logic [7:0] v_bad2 [7] = '{8'hA5, 8'h77, 8'h11, 8'h22,
                             8'h33, 8'h44, 8'h00};
  logic [7:0] v_part [3] = '{8'hA5, 8'h12, 8'hEF};
  logic [7:0] v_next [7] = '{8'hA5, 8'h01, 8'h04, 8'h03,
                             8'h02, 8'h01, 8'h05};
  logic [7:0] v_syncd [7] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5,
                              8'hA5, 8'hA5, 8'hA5};

  always @(posedge clk) cyc <= cyc + 1;

  // Transceiver model: FIFO outputs move on the falling edge.
  always @(negedge clk) begin
    if (uart_send_flag) begin
      txlog.push_back(uart_send_data);
      txcyc.push_back(cyc);
    end
    if (uart_recv_flag) begin
      if (rxq.size() != 0) void'(rxq.pop_front());
      npop++;
      last_pop = cyc;
    end
    if (rx_valid) begin
      nvalid++;
      valid_cyc = cyc;
    end
    if (rx_err) begin
      nerr++;
      err_cyc = cyc;
    end
    uart_receivable = (rxq.size() != 0);
    uart_recv_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rx();
    npop   = 0;
    nvalid = 0;
    nerr   = 0;
  endtask

  task automatic send_frame(input logic [7:0] t,
                            input logic [31:0] w,
                            output int e0);
    tx_tag   = t;
    tx_word  = w;
    tx_valid = 1'b1;
    tick();
    e0       = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 200; i++) begin
      if (txlog.size() >= n) break;
      tick();
    end
    chk("wait_tx", 32'(txlog.size() >= n), 32'd1);
  endtask

  task automatic chk_rst_vals();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_err", rx_err, 0);
    chk("rst_rx_tag", rx_tag, 0);
    chk("rst_rx_word", rx_word, 0);
    chk("rst_send_flag", uart_send_flag, 0);
    chk("rst_send_data", uart_send_data, 0);
    chk("rst_recv_flag", uart_recv_flag, 0);
  endtask

  initial begin
    int e0, e1, s_end;
    tx_valid        = 1'b0;
    tx_tag          = 8'h00;
    tx_word         = 32'h0;
    uart_sendable   = 1'b1;
    uart_receivable = 1'b0;
    uart_recv_data  = 8'h00;
    clr_rx();
    repeat (3) tick();
    chk_rst_vals();
    rst = 1'b0;
    tick();

    // TX basic
    txlog.delete();
    txcyc.delete();
    send_frame(8'h12, 32'hDEADBEEF, e0);
    chk("tx_ready_busy", tx_ready, 0);
    repeat (12) tick();
    chk("tx_ready_e12", tx_ready, 0);
    tick();
    chk("tx_ready_e13", tx_ready, 1);
    // Back-to-back frame, accepted at e0+14.
    send_frame(8'h12, 32'hDEADBEEF, e1);
    chk("b2b_accept", e1 - e0, 14);
    chk("tx_cnt", txlog.size(), 7);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("tx_b%0d", k), txlog[k], exp_a[k]);
      chk($sformatf("tx_c%0d", k), txcyc[k] - e0, 2 * k + 1);
    end

    // TX stall after byte 2 of the second frame
    wait_tx(10);
    uart_sendable = 1'b0;
    repeat (20) tick();
    chk("stall_none", txlog.size(), 10);
    uart_sendable = 1'b1;
    s_end = cyc;
    wait_tx(14);
    chk("b2b_first", txcyc[7] - e1, 1);
    chk("stall_b3_cyc", txcyc[10] - s_end, 1);
    for (int k = 0; k < 7; k++)
      chk($sformatf("stall_b%0d", k), txlog[7 + k], exp_a[k]);
    repeat (4) tick();
    chk("stall_total", txlog.size(), 14);

    // RX good frame with leading junk
    clr_rx();
    foreach (v_good[i]) rxq.push_back(v_good[i]);
    repeat (30) tick();
    chk("rxg_pops", npop, 9);
    chk("rxg_valid", nvalid, 1);
    chk("rxg_err", nerr, 0);
    chk("rxg_tag", rx_tag, 8'h12);
    chk("rxg_word", rx_word, 32'hDEADBEEF);
    chk("rxg_when", valid_cyc, last_pop);

    // RX bad checksum
    clr_rx();
    foreach (v_bad1[i]) rxq.push_back(v_bad1[i]);
    repeat (20) tick();
    chk("rxb_err", nerr, 1);
    chk("rxb_valid", nvalid, 0);
    chk("rxb_when", err_cyc, last_pop);
    clr_rx();
    foreach (v_bad2[i]) rxq.push_back(v_bad2[i]);
    repeat (20) tick();
    chk("rxb2_err", nerr, 1);
    chk("rxb2_valid", nvalid, 0);
    chk("rxb2_tag", rx_tag, 8'h12);
    chk("rxb2_word", rx_word, 32'hDEADBEEF);

    // A5 bytes inside a frame are data
    clr_rx();
    foreach (v_syncd[i]) rxq.push_back(v_syncd[i]);
    repeat (20) tick();
    chk("rxs_valid", nvalid, 1);
    chk("rxs_err", nerr, 0);
    chk("rxs_word", rx_word, 32'hA5A5A5A5);

    // RX timeout then a fresh frame
    clr_rx();
    foreach (v_part[i]) rxq.push_back(v_part[i]);
    repeat (70) tick();
    chk("rxt_pops", npop, 3);
    chk("rxt_err", nerr, 1);
    chk("rxt_delay", err_cyc - last_pop, 50);
    chk("rxt_valid", nvalid, 0);
    clr_rx();
    foreach (v_next[i]) rxq.push_back(v_next[i]);
    repeat (20) tick();
    chk("rxn_valid", nvalid, 1);
    chk("rxn_err", nerr, 0);
    chk("rxn_tag", rx_tag, 8'h01);
    chk("rxn_word", rx_word, 32'h01020304);

    // Reset in the middle of both directions
    clr_rx();
    txlog.delete();
    txcyc.delete();
    foreach (exp_a[i]) rxq.push_back(exp_a[i]);
    send_frame(8'h12, 32'hDEADBEEF, e0);
    for (int i = 0; i < 100; i++) begin
      if (txlog.size() >= 4 && npop >= 5) break;
      tick();
    end
    chk("mid_reached", 32'(txlog.size() >= 4 && npop >= 5), 1);
    rst = 1'b1;
    #1;
    chk_rst_vals();
    rxq.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", nvalid, 0);

    txlog.delete();
    txcyc.delete();
    send_frame(8'h5A, 32'h11223344, e0);
    wait_tx(7);
    for (int k = 0; k < 7; k++)
      chk($sformatf("rtx_b%0d", k), txlog[k], exp_b[k]);
    clr_rx();
    foreach (txlog[i]) rxq.push_back(txlog[i]);
    repeat (20) tick();
    chk("rrx_valid", nvalid, 1);
    chk("rrx_err", nerr, 0);
    chk("rrx_tag", rx_tag, 8'h5A);
    chk("rrx_word", rx_word, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_packet_link.md
# uart_packet_link

Packet layer on the client side of the UART byte interface: it drives the byte-level send/receive FIFO handshake of the UART transceiver. The TX half serializes a tagged 32-bit word into a fixed 7-byte frame. The RX half hunts for frames in the received byte stream, checks them and delivers tag+word to the CPU-side memory/IO logic. It sits between the transceiver and the core's UART bus adapter.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000: max CLK cycles between consecutive RX bytes inside a frame before the frame is abandoned.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- tx_valid  in  1  request to send a frame
- tx_ready  out  1  high in TX IDLE; a frame is accepted on tx_valid && tx_ready
- tx_tag  in  8  frame tag, sampled on accept
- tx_word  in  32  frame payload, sampled on accept
- rx_valid  out  1  one-cycle pulse: good frame delivered
- rx_tag  out  8  tag of last good frame, held until next good frame
- rx_word  out  32  payload of last good frame, held until next good frame
- rx_err  out  1  one-cycle pulse: checksum mismatch or inter-byte timeout
- uart_send_flag  out  1  one-cycle push strobe to the transceiver send FIFO
- uart_send_data  out  8  byte pushed, valid with uart_send_flag
- uart_sendable  in  1  send FIFO not full
- uart_recv_flag  out  1  one-cycle pop strobe to the transceiver receive FIFO
- uart_recv_data  in  8  head of receive FIFO, valid while uart_receivable
- uart_receivable  in  1  receive FIFO not empty

## Operation
- Frame, in byte order: 0xA5, tag, w[7:0], w[15:8], w[23:16], w[31:24], chk.
  - chk = tag ^ all four payload bytes.
- FIFO rules. The FIFO status flags update one cycle after a strobe, so:
  - push only when uart_sendable && !uart_send_flag (registered);
  - pop only when uart_receivable && !uart_recv_flag (registered);
  - consequently there is at most one strobe per two cycles per direction.
- TX FSM:
  - IDLE: tx_ready=1. On accept, latch tag/word, clear the byte index, go to SEND.
  - SEND: at each allowed push, drive byte[idx] and increment idx. The push of byte 6 returns to IDLE on the same edge.
  - tx_valid while not ready is ignored; no back-pressure on the inputs beyond tx_ready.
- RX FSM:
  - HUNT: pop and discard every byte that is not 0xA5. On 0xA5, go to COLLECT with idx=1 and clear the running XOR.
  - COLLECT: pop bytes 1..5 into the tag/word shadow registers and fold each into the running XOR.
    - On byte 6, compare it with the running XOR. Match: update rx_tag/rx_word and pulse rx_valid. Mismatch: pulse rx_err, rx_tag/rx_word unchanged.
    - Either way, return to HUNT.
  - 0xA5 inside COLLECT is plain data; there is no mid-frame resync.
  - Timeout counter clears on every pop and counts in COLLECT only. At TIMEOUT_CYCLES-1 without a pop: pulse rx_err, go to HUNT.
- Reset (any time): TX→IDLE, RX→HUNT, counters/indices 0.
  - Reset values: tx_ready=1, rx_valid=0, rx_err=0, rx_tag=0, rx_word=0, uart_send_flag=0, uart_send_data=0, uart_recv_flag=0.
  - A partial frame is abandoned. The transceiver is reset by the same RST, so no stale bytes remain.
- TX and RX are fully independent; simultaneous push and pop in one cycle are legal.

## Timing
- All outputs registered except tx_ready (decode of TX state).
- TX, accept at edge 0 with uart_sendable held high: pushes at edges 1,3,5,7,9,11,13; tx_ready high again after edge 13. Back-to-back frames: next accept at edge 14, first push at edge 15.
- uart_sendable low stalls the current byte indefinitely; the index does not advance.
- RX: a byte is consumed at the edge its pop strobe is raised, with uart_recv_data sampled at that edge.
  - rx_valid/rx_err assert on the edge that pops the checksum byte, high for exactly one cycle.
  - With the FIFO pre-filled, a whole frame is consumed in 13 cycles (pops at edges 1,3,…,13).
- Timeout error is a one-cycle pulse. The next byte is then handled in HUNT.

## Structure
- Shared package uart_pkt_pkg: SYNC_BYTE=8'hA5, FRAME_LEN=7, TX state encoding {IDLE,SEND}, RX state encoding {HUNT,COLLECT}, byte-index width 3.
- Sub-module uart_pkt_rx holds the RX FSM, XOR, timeout counter and output registers. The TX FSM stays inline in uart_packet_link.

## Test plan
- TX basic: tx_tag=0x12, tx_word=0xDEADBEEF, sendable=1 → pushes A5 12 EF BE AD DE 30 at edges 1..13 (odd); tx_ready low during, high after edge 13.
- TX stall: drop uart_sendable for 20 cycles after byte 2 → no pushes during the stall, byte 3 (0xBE) on the first allowed cycle after it, no byte lost or duplicated.
- RX good + hunt: feed 00 FF A5 12 EF BE AD DE 30 → bytes 00 and FF discarded; one rx_valid pulse with rx_tag=0x12, rx_word=0xDEADBEEF; rx_err=0.
- RX bad checksum: feed A5 12 EF BE AD DE 31 → rx_err pulses once, rx_valid=0, rx_tag/rx_word keep the previous values.
- RX timeout: TIMEOUT_CYCLES=50; feed A5 12 EF, then idle 60 cycles → rx_err pulses 50 cycles after the last pop; following frame A5 01 04 03 02 01 05 → rx_valid, rx_word=0x01020304.
- Reset mid-frame: assert RST after TX byte 3 and RX byte 4 → outputs at reset values immediately; a fresh frame afterwards is sent and received correctly.
